// File: rtl/mips_dbus_pkg.sv
// Shared constants for the mips_dbus data-bus bridge: MMIO register offsets,
// STATUS bit layout and the address bit that selects the MMIO window.
package mips_dbus_pkg;

  typedef enum logic [1:0] {
    OFF_TXDATA  = 2'd0,
    OFF_STATUS  = 2'd1,
    OFF_CYCLE   = 2'd2,
    OFF_SCRATCH = 2'd3
  } mmio_off_e;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 4;

  // The top address bit splits data memory (0) from the register window (1).
  function automatic int mmio_sel_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/mips_dbus_if.sv
// Core-side memory-stage bus plus the transmit byte stream, bundled so the
// bridge and its neighbours share one port list.
interface mips_dbus_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_memwrite;
  logic [WIDTH-1:0] cpu_rdata;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;

  // master: the core and the byte consumer; slave: the bridge.
  modport master (
    output cpu_addr, cpu_wdata, cpu_memwrite, tx_ready,
    input  cpu_rdata, tx_valid, tx_data
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_memwrite, tx_ready,
    output cpu_rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/mips_dbus_byte_fifo.sv
// Byte-wide transmit FIFO with registered storage and a head that is read
// straight from the storage array (no push-to-output bypass).
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mips_dbus.sv
// Memory-stage data-bus bridge: routes each access to word-addressed data
// memory or to a small register window (TX FIFO, STATUS, CYCLE, SCRATCH).
module mips_dbus
  import mips_dbus_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DMEMDEPTH = 14,
  parameter int FIFODEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_dbus_if.slave           bus,
  output logic [DMEMDEPTH-1:0] dmem_addr,
  output logic [WIDTH-1:0]     dmem_wd,
  output logic                 dmem_memwrite,
  input  logic [WIDTH-1:0]     dmem_rd
);
  localparam int SEL_BIT = mmio_sel_bit(WIDTH);
  localparam int CW      = $clog2(FIFODEPTH) + 1;

  logic             mmio_sel;
  mmio_off_e        reg_sel;
  logic             mmio_wr;
  logic             wr_txdata, wr_status, wr_cycle, wr_scratch;

  logic             fifo_empty, fifo_full, fifo_push_ok;
  logic [CW-1:0]    fifo_count;
  logic [7:0]       fifo_dout;

  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] cycle_q, cycle_d;
  logic [WIDTH-1:0] scratch_q, scratch_d;
  logic [WIDTH-1:0] status_word;
  logic [WIDTH-1:0] mmio_rdata;
  logic             unused_bits;

  assign mmio_sel = bus.cpu_addr[SEL_BIT];
  assign reg_sel  = mmio_off_e'(bus.cpu_addr[3:2]);
  assign mmio_wr  = mmio_sel && bus.cpu_memwrite;

  assign wr_txdata  = mmio_wr && (reg_sel == OFF_TXDATA);
  assign wr_status  = mmio_wr && (reg_sel == OFF_STATUS);
  assign wr_cycle   = mmio_wr && (reg_sel == OFF_CYCLE);
  assign wr_scratch = mmio_wr && (reg_sel == OFF_SCRATCH);

  // Address and data go to memory unchanged; only the write strobe is gated.
  assign dmem_addr     = bus.cpu_addr[DMEMDEPTH+1:2];
  assign dmem_wd       = bus.cpu_wdata;
  assign dmem_memwrite = bus.cpu_memwrite && !mmio_sel;

  // Address bits outside the decode (byte offset, window alias bits).
  assign unused_bits = ^bus.cpu_addr;

  byte_fifo #(
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_txdata),
    .din     (bus.cpu_wdata[7:0]),
    .pop     (bus.tx_valid && bus.tx_ready),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count),
    .push_ok (fifo_push_ok)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_dout;

  always_comb begin
    overflow_d = overflow_q;
    if (wr_txdata && !fifo_push_ok) begin
      overflow_d = 1'b1;
    end else if (wr_status && bus.cpu_wdata[STAT_OVF]) begin
      overflow_d = 1'b0;
    end

    cycle_d = cycle_q + WIDTH'(1);
    if (wr_cycle) begin
      cycle_d = '0;
    end

    scratch_d = scratch_q;
    if (wr_scratch) begin
      scratch_d = bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      scratch_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_OVF]   = overflow_q;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);

    mmio_rdata = '0;
    case (reg_sel)
      OFF_TXDATA:  mmio_rdata = '0;
      OFF_STATUS:  mmio_rdata = status_word;
      OFF_CYCLE:   mmio_rdata = cycle_q;
      OFF_SCRATCH: mmio_rdata = scratch_q;
      default:     mmio_rdata = '0;
    endcase
  end

  assign bus.cpu_rdata = mmio_sel ? mmio_rdata : dmem_rd;

endmodule

// File: doc/mips_dbus.md
# mips_dbus

Data-bus bridge directly downstream of the pipelined core's memory-stage port (`aluout`, `writedata`, `memwrite`, `readdata`). It decodes each access to either the word-addressed data memory or a small memory-mapped register window. The window contains:
- a byte-wide transmit FIFO drained through a valid/ready handshake;
- a free-running cycle counter;
- a scratch register.

Reads are combinational so the core's memory stage timing is unchanged. Writes commit on the clock edge.

## Interface
- `WIDTH`, 32: data/address width.
- `DMEMDEPTH`, 14: data-memory word-address bits.
- `FIFODEPTH`, 4: transmit FIFO entries. Must be a power of two and ≥2.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-low: `rst`=0 at a posedge resets all state.
- `cpu_addr`  in  WIDTH  byte address, driven from core `aluout`.
- `cpu_wdata`  in  WIDTH  store data, driven from core `writedata`.
- `cpu_memwrite`  in  1  store strobe, driven from core `memwrite`.
- `cpu_rdata`  out  WIDTH  load data, drives core `readdata`.
- `dmem_addr`  out  DMEMDEPTH  word address to data memory.
- `dmem_wd`  out  WIDTH  data-memory write data.
- `dmem_memwrite`  out  1  data-memory write enable.
- `dmem_rd`  in  WIDTH  data-memory read data.
- `tx_valid`  out  1  FIFO head valid.
- `tx_data`  out  8  FIFO head byte.
- `tx_ready`  in  1  consumer accepts head this cycle.

## Operation
**Decode**
- `cpu_addr[WIDTH-1]`=0 selects DMEM.
  - `dmem_addr` = `cpu_addr[DMEMDEPTH+1:2]`.
  - `dmem_wd` = `cpu_wdata`.
  - `dmem_memwrite` = `cpu_memwrite`.
  - `cpu_rdata` = `dmem_rd`.
- `cpu_addr[WIDTH-1]`=1 selects MMIO. `dmem_memwrite` is forced to 0.
  - The register is chosen by `cpu_addr[3:2]`; all other address bits are ignored.
  - `dmem_addr` and `dmem_wd` pass through unchanged.

**MMIO registers**
- Offset 0, TXDATA: a write pushes `cpu_wdata[7:0]`; a read returns 0.
- Offset 1, STATUS (read):
  - bit0 empty;
  - bit1 full;
  - bit2 overflow (sticky);
  - bits[7:4] count, zero-extended;
  - all other bits 0.
  - A write with `cpu_wdata[2]`=1 clears overflow (write-1-to-clear). Other written bits are ignored.
- Offset 2, CYCLE: a read returns the counter; any write clears it to 0.
- Offset 3, SCRATCH: plain read/write.

**FIFO**
- `tx_valid` = !empty. `tx_data` = head entry.
- Pop when `tx_valid` && `tx_ready`.
- Push is accepted when !full, or when full with a pop in the same cycle.
- A push to a full FIFO with no pop that cycle is dropped and sets overflow.
- Simultaneous push and pop: count is unchanged, and head and tail pointers both advance.
- Pointers are log2(`FIFODEPTH`) bits and wrap modulo `FIFODEPTH`. The count register is log2(`FIFODEPTH`)+1 bits.

**Counters and reset**
- CYCLE increments by 1 every cycle and wraps from 2^WIDTH−1 to 0. A write in the same cycle wins, giving 0 at the next edge.
- On reset: FIFO empty, pointers 0, storage 0, overflow 0, CYCLE 0, SCRATCH 0.
- Output values after reset: `tx_valid`=0 and `tx_data`=0. Other outputs follow their combinational definitions.
- Reset mid-transfer discards FIFO contents without completing the handshake.

## Timing
- DMEM path and all MMIO reads are zero-latency combinational. Reads return the pre-edge register value.
- A byte pushed at edge N is visible on `tx_valid`/`tx_data` after edge N; no bypass from push to output in the same cycle.
- `tx_data` is held stable while `tx_valid`=1 and `tx_ready`=0.
- STATUS reflects state after the previous edge. A push and a STATUS read cannot occur in the same cycle, since the core issues a single access per cycle.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package `mips_dbus_pkg` holds:
  - MMIO offsets `OFF_TXDATA`=0, `OFF_STATUS`=1, `OFF_CYCLE`=2, `OFF_SCRATCH`=3;
  - STATUS bit positions;
  - the MMIO select bit index.
- One sub-module, `byte_fifo` (parameter `DEPTH`). Ports: `clk`, `rst`, `push`, `din`, `pop`, `dout`, `empty`, `full`, `count`, `push_ok`. It is instantiated once.
- The top level holds decode, the register file, and the counter.

## Test plan
- DMEM pass-through: store 0xDEADBEEF to 0x00000010 → `dmem_addr`=4 and `dmem_memwrite`=1. Load from 0x00000010 with `dmem_rd`=0x12345678 → `cpu_rdata`=0x12345678 in the same cycle.
- MMIO isolation: store to 0x8000000C with value 0xA5 → `dmem_memwrite`=0. SCRATCH read returns 0x000000A5.
- FIFO fill/overflow with `tx_ready`=0:
  - push 0x41, 0x42, 0x43, 0x44, 0x45 → STATUS=0x46 (count 4, full, overflow);
  - `tx_data`=0x41;
  - write 0x4 to STATUS → overflow clears, STATUS=0x42.
- Drain order: raise `tx_ready` → `tx_data` sequence 0x41, 0x42, 0x43, 0x44 on consecutive cycles. `tx_valid` falls after the 4th pop.
- Full with simultaneous push and pop: FIFO full, `tx_ready`=1, push 0x55 → accepted, overflow stays 0, count stays 4, and 0x55 later emerges last.
- Counter and reset:
  - after 100 cycles out of reset, CYCLE reads 100;
  - write CYCLE → next read returns 0;
  - assert `rst`=0 with 2 bytes queued → `tx_valid`=0 and STATUS=0x01 after the edge.
